// File: rtl/multicycle_ctrl.sv
// Multicycle controller: F/D/E/M/W sequencer for a small MIPS-like subset.
// The opcode and an is-NOP flag are captured in D. Every E/M/W decision
// uses those captured values, so the IR may change after decode.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       rf_we,
    output logic       rf_wsel,
    output logic       wb_src,
    output logic       alu_imm,
    output logic [2:0] state,
    output logic       retire,
    output logic       illegal
);
    typedef enum logic [2:0] {
        S_F = 3'b001,
        S_D = 3'b010,
        S_E = 3'b011,
        S_M = 3'b100,
        S_W = 3'b101
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       nop_q, nop_d;
    logic       is_nop;

    assign is_nop = (op == OP_R) && (func == 6'h00);
    assign state  = state_q;

    // State and decoded-instruction registers. Reset aborts at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_F;
            op_q    <= 6'h00;
            nop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            nop_q   <= nop_d;
        end
    end

    // Next state and control outputs. All outputs are held at 0 while
    // reset is high, so an aborted access drops its request immediately.
    always_comb begin
        state_d  = S_F;
        op_d     = op_q;
        nop_d    = nop_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 2'd0;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        wb_src   = 1'b0;
        alu_imm  = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_F: begin
                    imem_req = 1'b1;
                    state_d  = S_F;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_D;
                    end
                end
                S_D: begin
                    op_d  = op;
                    nop_d = is_nop;
                    if (is_nop) begin
                        retire = 1'b1;
                    end else begin
                        case (op)
                            OP_J: begin
                                pc_we  = 1'b1;
                                pc_src = 2'd2;
                                retire = 1'b1;
                            end
                            OP_R, OP_BEQ, OP_ADDI, OP_LW, OP_SW: state_d = S_E;
                            default: illegal = 1'b1;
                        endcase
                    end
                end
                S_E: begin
                    case (op_q)
                        OP_R:    if (!nop_q) state_d = S_W;
                        OP_ADDI: begin alu_imm = 1'b1; state_d = S_W; end
                        OP_LW:   begin alu_imm = 1'b1; state_d = S_M; end
                        OP_SW:   begin alu_imm = 1'b1; state_d = S_M; end
                        OP_BEQ: begin
                            pc_we  = zero;
                            pc_src = 2'd1;
                            retire = 1'b1;
                        end
                        default: state_d = S_F;
                    endcase
                end
                S_M: begin
                    // Request and write strobe depend only on the latched op,
                    // so they stay stable while waiting on dmem_ready.
                    dmem_req = 1'b1;
                    dmem_we  = (op_q == OP_SW);
                    state_d  = S_M;
                    if (dmem_ready) begin
                        if (op_q == OP_LW) begin
                            state_d = S_W;
                        end else begin
                            state_d = S_F;
                            retire  = 1'b1;
                        end
                    end
                end
                S_W: begin
                    rf_we   = 1'b1;
                    retire  = 1'b1;
                    rf_wsel = (op_q == OP_R);
                    wb_src  = (op_q == OP_LW);
                end
                default: state_d = S_F;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. Stimulus drives one cycle of inputs
// and queues the hand-computed output vector. The monitor pops and compares
// on the falling edge.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = '0, func = '0;
    logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, rf_wsel;
    logic       wb_src, alu_imm, retire, illegal;
    logic [1:0] pc_src;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    localparam logic [2:0] F = 3'b001, D = 3'b010, E = 3'b011, M = 3'b100, W = 3'b101;
    localparam logic [12:0] IMQ = 13'h1000, DMQ = 13'h0800, DWE = 13'h0400,
                            IRW = 13'h0200, PCW = 13'h0100, PS2 = 13'h0080,
                            PS1 = 13'h0040, RFW = 13'h0020, WSL = 13'h0010,
                            WBS = 13'h0008, AIM = 13'h0004, RET = 13'h0002,
                            ILL = 13'h0001;
    localparam logic [12:0] FETCH = IMQ | IRW | PCW;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we),
        .rf_wsel(rf_wsel), .wb_src(wb_src), .alu_imm(alu_imm),
        .state(state), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [2:0] st, input logic [12:0] fl);
        return {st, fl};
    endfunction

    // One cycle of stimulus; the expected outputs for that cycle are queued.
    task automatic step(input logic [5:0] o, input logic [5:0] fn, input logic z,
                        input logic ir, input logic dr, input logic rst,
                        input logic [15:0] e);
        @(posedge clk);
        #1;
        op = o; func = fn; zero = z; imem_ready = ir; dmem_ready = dr; reset = rst;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the presented outputs against the scoreboard head.
    always @(negedge clk) begin
        logic [15:0] got, e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src,
                   rf_we, rf_wsel, wb_src, alu_imm, retire, illegal};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, got, e);
            end
        end
    end

    initial begin
        // Reset: F, everything else 0, even with both readys high.
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, mk(F, 13'h0));
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b1, 1'b1, mk(F, 13'h0));
        // First cycle after release: fetch request, held while imem not ready.
        step(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, mk(F, IMQ));
        // ADDI; op is scrambled after D to prove the latched op is used.
        step(6'h08, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h08, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, 13'h0));
        step(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(E, AIM));
        step(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(W, RFW | RET));
        // LW, two wait cycles in M; stray imem_ready in M ignored.
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, 13'h0));
        step(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(E, AIM));
        step(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(M, DMQ));
        step(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(M, DMQ));
        step(6'h23, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, mk(M, DMQ));
        step(6'h23, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(W, RFW | WBS | RET));
        // BEQ taken, then BEQ not taken.
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h04, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, 13'h0));
        step(6'h04, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, mk(E, PCW | PS1 | RET));
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h04, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, 13'h0));
        step(6'h04, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(E, PS1 | RET));
        // J, then NOP.
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h02, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, PCW | PS2 | RET));
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, RET));
        // R-type add (func 0x20): writes rd.
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h00, 6'h20, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, 13'h0));
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(E, 13'h0));
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(W, RFW | WSL | RET));
        // Illegal opcode, then a stray dmem_ready while held in F.
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h3F, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, ILL));
        step(6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, mk(F, IMQ));
        step(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, mk(F, IMQ));
        // SW, zero-wait.
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, 13'h0));
        step(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(E, AIM));
        step(6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, mk(M, DMQ | DWE | RET));
        // SW aborted by reset while held in M.
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(D, 13'h0));
        step(6'h2B, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(E, AIM));
        step(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, mk(M, DMQ | DWE));
        step(6'h2B, 6'h00, 1'b0, 1'b0, 1'b1, 1'b1, mk(F, 13'h0));
        step(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, mk(F, IMQ));
        step(6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, mk(F, FETCH));
        step(6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, mk(D, RET));

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
